// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg
//   Parametrised channel multiplexer with a registered output stage and a
//   valid/ready handshake on both sides. It replaces the old 8-bit 4:1
//   combinational mux. A channel is chosen in one of two ways:
//     mode = 0 : fixed select, where `sel` names the channel.
//     mode = 1 : round-robin, where the first valid channel is taken,
//                scanning from the round-robin pointer upward and wrapping.
//   The output register can drain and load on the same edge, so it sustains
//   one word per cycle.
//
// Parameters
//   WIDTH    : data bits per channel
//   CHANNELS : number of input channels (2..16)
//   SEL_W    : channel-index width, equal to ceil(log2(CHANNELS))
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_data   : flattened channel data, channel k is [k*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, one-hot or zero, forced to 0 during rst
//   mode      : 0 = fixed select, 1 = round-robin
//   sel       : channel index used in fixed-select mode
//   out_data  : registered selected word
//   out_valid : output register holds a word
//   out_ready : consumer accepts the word
//   out_chan  : source channel of out_data
//   grant_cnt : saturating 16-bit count of output transfers. This port exists
//               only when the macro MUX_RR_GRANT_CNT_EN is defined.
// -----------------------------------------------------------------------------
module mux_rr_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
`ifdef MUX_RR_GRANT_CNT_EN
  ,
  output logic [15:0]               grant_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load_en;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [CHANNELS-1:0] w_grant_oh;
  logic [WIDTH-1:0]    w_grant_data;
  logic                w_xfer;
  logic [SEL_W-1:0]    w_ptr_nxt;

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

  // The register can accept a word when it is empty or is draining this cycle.
  assign w_load_en = !out_valid || out_ready;

  // Grant selection. In round-robin mode the winner is the valid channel at
  // the smallest forward distance from r_ptr. A sel value outside the channel
  // range matches no k, so it yields no grant.
  always_comb begin : grant_sel
    int v_best;
    int v_dist;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    v_best      = CHANNELS;
    v_dist      = 0;
    if (!mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (k == int'(sel) && in_valid[k]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(k);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        v_dist = (k - int'(r_ptr) + CHANNELS) % CHANNELS;
        if (in_valid[k] && v_dist < v_best) begin
          v_best      = v_dist;
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(k);
        end
      end
    end
  end

  // Decode the grant to one-hot form and pick the granted word. The loop uses
  // constant indices only, so it never reads past the last channel.
  always_comb begin : grant_decode
    w_grant_oh   = '0;
    w_grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_grant_vld && k == int'(w_grant_idx)) begin
        w_grant_oh[k] = 1'b1;
        w_grant_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is gated by reset, so no handshake can complete on a reset edge.
  assign in_ready  = (!rst && w_load_en) ? w_grant_oh : '0;
  assign w_xfer    = |(in_valid & in_ready);
  assign w_ptr_nxt = (int'(w_grant_idx) == CHANNELS - 1) ? '0
                                                         : w_grant_idx + 1'b1;

  // Output-stage next state. A load always wins over a drain, so the register
  // is never emptied on an edge that also loads it.
  always_comb begin : state_nxt
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = ST_FULL;
    end else if (r_state == ST_FULL && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: out_data and out_chan are reset explicitly because the consumer may
  // observe them right after reset. They are plain flops, not a memory array.
  always_ff @(posedge clk) begin : data_reg
    if (rst) begin
      r_data <= '0;
      r_chan <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_data <= w_grant_data;
      r_chan <= w_grant_idx;
      if (mode) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

`ifdef MUX_RR_GRANT_CNT_EN
  logic [15:0] r_grant_cnt;

  always_ff @(posedge clk) begin : grant_cnt_reg
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (out_valid && out_ready && r_grant_cnt != 16'hFFFF) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_reg
//   Self-checking bench for mux_rr_reg (WIDTH=8, CHANNELS=4). A behavioural
//   model tracks the output word, its channel, the round-robin pointer and
//   the grant count. On every falling edge the model is compared against the
//   DUT and then advanced using the inputs that the next rising edge will
//   sample. Directed sequences with literal expectations pin the model down,
//   and a randomised phase follows them.
// -----------------------------------------------------------------------------
module tb_mux_rr_reg;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_chan;
`ifdef MUX_RR_GRANT_CNT_EN
  logic [15:0]               grant_cnt;
`endif

  mux_rr_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
`ifdef MUX_RR_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model state: the value each output must hold after the next
  // rising edge has been applied.
  bit         chk_en = 0;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;
  int         m_cnt;

  // Returns the channel whose transfer happens this cycle, or -1 if none.
  function automatic int model_grant();
    int idx;
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (!mode) begin
      if (int'(sel) < CHANNELS && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int off = 0; off < CHANNELS; off++) begin
      idx = (m_ptr + off) % CHANNELS;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      logic [3:0] exp_rdy;
      g       = model_grant();
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
      check("in_ready",  32'(in_ready),  32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data",  32'(out_data),  32'(m_data));
      check("out_chan",  32'(out_chan),  32'(m_chan));
`ifdef MUX_RR_GRANT_CNT_EN
      check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
      if (rst) begin
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0; m_cnt = 0;
      end else begin
        if (m_valid && out_ready && m_cnt < 65535) m_cnt++;
        if (g >= 0) begin
          m_data  = in_data[g*WIDTH +: WIDTH];
          m_chan  = g;
          m_valid = 1;
          if (mode) m_ptr = (g + 1) % CHANNELS;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] PAT = {8'h0F, 8'hF0, 8'h55, 8'hAA};

  initial begin
    logic [7:0] exp_w [4];
    int         rr_seq [6];
    exp_w  = '{8'hAA, 8'h55, 8'hF0, 8'h0F};
    rr_seq = '{0, 1, 2, 3, 0, 1};

    rst = 1; in_data = '0; in_valid = '0; mode = 0; sel = '0; out_ready = 0;
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0; m_cnt = 0;
    step();
    step();
    chk_en = 1;
    step();

    // Fixed select, stepping sel 0..3.
    rst = 0; in_data = PAT; in_valid = 4'hF; out_ready = 1; mode = 0; sel = 0;
    #1 check("t1_rdy0", 32'(in_ready), 32'h1);
    for (int s = 1; s < 4; s++) begin
      step();
      check("t1_data", 32'(out_data), 32'(exp_w[s-1]));
      check("t1_chan", 32'(out_chan), 32'(s - 1));
      sel = SEL_W'(s);
      #1 check("t1_rdy", 32'(in_ready), 32'(1 << s));
    end
    step();
    check("t1_data3", 32'(out_data), 32'h0F);
    check("t1_chan3", 32'(out_chan), 32'd3);

    // Round-robin with all channels valid.
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_chan",  32'(out_chan),  32'(rr_seq[i]));
      check("t2_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin with only channels 1 and 3 valid, starting from reset.
    rst = 1;
    step();
    rst = 0; in_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      #1 check("t3_rdy02", 32'(in_ready & 4'b0101), 32'd0);
      step();
      check("t3_chan", 32'(out_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure after loading AA.
    rst = 1;
    step();
    rst = 0; mode = 0; sel = 0; in_valid = 4'hF; out_ready = 0;
    step();
    check("t4_load", 32'(out_data), 32'hAA);
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_rdy0", 32'(in_ready), 32'd0);
      step();
      check("t4_hold",  32'(out_data),  32'hAA);
      check("t4_valid", 32'(out_valid), 32'd1);
    end
    sel = 1; out_ready = 1;
    #1 check("t4_rel_rdy", 32'(in_ready), 32'h2);
    step();
    check("t4_next", 32'(out_data), 32'h55);

    // Reset while full and stalled; the pointer must return to channel 0.
    mode = 1;
    step();
    step();
    out_ready = 0;
    step();
    rst = 1;
    step();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_data",  32'(out_data),  32'd0);
    check("t5_chan",  32'(out_chan),  32'd0);
    rst = 0; out_ready = 1;
    #1 check("t5_rdy", 32'(in_ready), 32'h1);
    step();
    check("t5_first", 32'(out_chan), 32'd0);
    check("t5_fdata", 32'(out_data), 32'hAA);

`ifdef MUX_RR_GRANT_CNT_EN
    // Five output transfers followed by two stalled cycles.
    rst = 1;
    step();
    rst = 0; mode = 0; sel = 0; in_valid = 4'hF; out_ready = 0;
    step();
    out_ready = 1;
    repeat (5) step();
    out_ready = 0;
    repeat (2) step();
    check("t6_cnt5", 32'(grant_cnt), 32'd5);
    rst = 1;
    step();
    check("t6_cnt0", 32'(grant_cnt), 32'd0);
    rst = 0;
`endif

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step();
      rst       = ($urandom_range(0, 39) == 0);
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      sel       = SEL_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor to the team's 8-bit 4:1 combinational mux.
- Selects one of CHANNELS input streams of WIDTH bits and holds the result in a registered output stage, using a valid/ready handshake.
- Two selection modes: fixed-select (select input drives the choice) and round-robin arbitration across the valid channels.
- Sits between multiple producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width per channel in bits.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed-select mode.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_chan  output  SEL_W  source channel index of out_data.

Behaviour:
- Reset, on the clk edge with rst=1:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is combinationally 0 whenever rst=1.
- Output stage states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid || out_ready.
- Grant g, combinational:
  - mode=0: g=sel if in_valid[sel], else no grant. A sel value >= CHANNELS gives no grant.
  - mode=1: g = the first k with in_valid[k], scanning rr_ptr, rr_ptr+1, … wrapping modulo CHANNELS. No grant if in_valid is all zero.
- in_ready[g] = load_en when a grant exists; every other bit is 0. There is never more than one bit high.
- Transfer on input k happens when in_valid[k] && in_ready[k]. On that edge:
  - out_data <= channel k data, out_chan <= k, out_valid <= 1.
  - If mode=1: rr_ptr <= (k+1) mod CHANNELS.
- Output side:
  - If out_valid && out_ready and no input transfer on the same edge: out_valid <= 0; out_data and out_chan hold their values.
  - Simultaneous drain and load: the new word replaces the old one with no bubble, giving full throughput of 1 word/cycle.
- Stall: while out_valid=1 && out_ready=0, out_data and out_chan stay stable and in_ready is all zero.
- Latency: 1 cycle from the accepting edge to out_valid.
- rr_ptr:
  - Unchanged in mode=0.
  - Unchanged when no transfer occurs.
  - Wraps from CHANNELS-1 to 0.
- Mode or sel changes take effect at the next arbitration and do not affect a word already held in the register.
- Reset while FULL: the word is discarded, out_valid=0 on the next cycle, and no handshake completes on that edge.

Optional Feature:
- Macro: MUX_RR_GRANT_CNT_EN.
- When defined:
  - Adds output port grant_cnt, 16 bits.
  - grant_cnt counts output transfers (out_valid && out_ready).
  - It saturates at 16'hFFFF and resets to 0 on rst.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Fixed mode, CHANNELS=4, WIDTH=8, in_data = {D=0F, C=F0, B=55, A=AA}, all in_valid=1, out_ready=1; sel stepping 0,1,2,3 one per cycle.
   -> out_data = AA, 55, F0, 0F with out_chan = 0..3, each one cycle after its sel value; in_ready one-hot matching sel.
2. Round-robin, all in_valid=1, out_ready=1 for 6 cycles.
   -> out_chan sequence 0,1,2,3,0,1; out_valid stays 1 after the first word; rr_ptr wraps.
3. Round-robin with in_valid=4'b1010 from reset.
   -> Grants alternate channel 1, channel 3, channel 1, …; channels 0 and 2 never get in_ready.
4. Backpressure: out_ready=0 for 3 cycles after the first load of AA, then 1.
   -> out_data=AA and out_valid=1 held stable; in_ready=0 throughout the stall; the next word loads on the release edge.
5. rst=1 asserted while FULL with out_ready=0.
   -> Next cycle out_valid=0, out_data=00, rr_ptr=0; the first round-robin grant after reset goes to channel 0.
6. With MUX_RR_GRANT_CNT_EN defined: 5 output transfers, then 2 stalled cycles.
   -> grant_cnt=5, unchanged during the stall; rst clears it to 0.
